fnd_scan_driver: RTL

FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

---
 rtl/fnd_scan_driver.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fnd_scan_driver.sv
// Four-digit 7-segment scan driver: converts a 14-bit binary count to BCD with a
// sequential double-dabble engine and multiplexes the digits at P_SCAN_HZ.
module fnd_scan_driver #(
  parameter int         P_CLK_HZ  = 100_000_000,
  parameter int         P_SCAN_HZ = 1000,
  parameter logic [3:0] P_DP_MASK = 4'b1010
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_fndcnt,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_seg,
  output logic [15:0] o_bcd,
  output logic        o_bcd_valid
);

  localparam int PRESC_TC = P_CLK_HZ / P_SCAN_HZ - 1;
  localparam int PRESC_W  = (PRESC_TC > 1) ? $clog2(PRESC_TC + 1) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC_V = PRESC_W'(PRESC_TC);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t       state_reg, state_next;
  logic [13:0]  r_last, r_last_next;
  logic [13:0]  shift_reg, shift_next;
  logic [15:0]  acc_reg, acc_next, acc_adj;
  logic [3:0]   bit_cnt_reg, bit_cnt_next;
  logic [15:0]  bcd_reg, bcd_next;
  logic         valid_reg, valid_next;

  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [1:0]   idx_reg, idx_next;
  logic         scan_tick;
  logic [3:0]   com_reg, com_next;
  logic [7:0]   seg_reg, seg_next;
  logic [3:0]   cur_nibble;

  // Add-3 correction on every BCD nibble that would overflow when doubled
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    r_last_next  = r_last;
    shift_next   = shift_reg;
    acc_next     = acc_reg;
    bit_cnt_next = bit_cnt_reg;
    bcd_next     = bcd_reg;
    valid_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_fndcnt != r_last) begin
          r_last_next  = i_fndcnt;
          shift_next   = (i_fndcnt > 14'd9999) ? 14'd9999 : i_fndcnt;
          acc_next     = 16'd0;
          bit_cnt_next = 4'd0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        acc_next     = {acc_adj[14:0], shift_reg[13]};
        shift_next   = {shift_reg[12:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + 4'd1;
        if (bit_cnt_reg == 4'd13) state_next = LOAD;
      end
      LOAD: begin
        bcd_next   = acc_reg;
        valid_next = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign scan_tick  = (presc_reg == PRESC_TC_V);
  assign presc_next = scan_tick ? '0 : presc_reg + 1'b1;
  assign idx_next   = idx_reg + {1'b0, scan_tick};
  assign cur_nibble = bcd_reg[idx_next*4 +: 4];

  // Select and segments are both built from idx_next so they switch together
  always_comb begin
    com_next = ~(4'b0001 << idx_next);
    seg_next = 8'hFF;
    case (cur_nibble)
      4'd0:    seg_next[6:0] = 7'h40;
      4'd1:    seg_next[6:0] = 7'h79;
      4'd2:    seg_next[6:0] = 7'h24;
      4'd3:    seg_next[6:0] = 7'h30;
      4'd4:    seg_next[6:0] = 7'h19;
      4'd5:    seg_next[6:0] = 7'h12;
      4'd6:    seg_next[6:0] = 7'h02;
      4'd7:    seg_next[6:0] = 7'h78;
      4'd8:    seg_next[6:0] = 7'h00;
      4'd9:    seg_next[6:0] = 7'h10;
      default: seg_next[6:0] = 7'h7F;
    endcase
    seg_next[7] = ~P_DP_MASK[idx_next];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= IDLE;
      r_last      <= '0;
      shift_reg   <= '0;
      acc_reg     <= '0;
      bit_cnt_reg <= '0;
      bcd_reg     <= '0;
      valid_reg   <= 1'b0;
      presc_reg   <= '0;
      idx_reg     <= '0;
      com_reg     <= 4'hF;
      seg_reg     <= 8'hFF;
    end else begin
      state_reg   <= state_next;
      r_last      <= r_last_next;
      shift_reg   <= shift_next;
      acc_reg     <= acc_next;
      bit_cnt_reg <= bit_cnt_next;
      bcd_reg     <= bcd_next;
      valid_reg   <= valid_next;
      presc_reg   <= presc_next;
      idx_reg     <= idx_next;
      com_reg     <= com_next;
      seg_reg     <= seg_next;
    end
  end

  assign o_fnd_com   = com_reg;
  assign o_fnd_seg   = seg_reg;
  assign o_bcd       = bcd_reg;
  assign o_bcd_valid = valid_reg;

endmodule
